// File: rtl/bat_regfile.sv
// General-purpose register bank for the Bat Amateur CPU: tri-state bus access, ALU/OUT taps and an
// off-bus two-cycle COPY engine. Define REGFILE_DEC_EN to add the REGS_DEC decrement strobes.
module bat_regfile #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned NUM_REGS  = 8,
    parameter int unsigned ALU_A_IDX = 0,
    parameter int unsigned ALU_B_IDX = 1,
    localparam int unsigned IDXW     = $clog2(NUM_REGS)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                HALT,
    inout  wire  [WIDTH-1:0]    BUS,
    input  logic [NUM_REGS-1:0] REGS_EN,
    input  logic [NUM_REGS-1:0] REGS_RW,
    input  logic [NUM_REGS-1:0] REGS_INC,
`ifdef REGFILE_DEC_EN
    input  logic [NUM_REGS-1:0] REGS_DEC,
`endif
    output logic [WIDTH-1:0]    ALU_IN1,
    output logic [WIDTH-1:0]    ALU_IN2,
    output logic [WIDTH-1:0]    OUT,
    input  logic                COPY_REQ,
    input  logic [IDXW-1:0]     COPY_SRC,
    input  logic [IDXW-1:0]     COPY_DST,
    output logic                COPY_BUSY,
    output logic                COPY_DONE,
    output logic                CONFLICT
);

    typedef enum logic [1:0] {StIdle, StRd, StWr} copy_state_e;

    logic [WIDTH-1:0] regs_q [NUM_REGS];
    logic [WIDTH-1:0] tmp_q;
    logic [IDXW-1:0]  src_q;
    logic [IDXW-1:0]  dst_q;
    copy_state_e      state_q;
    logic             done_q;
    logic             conflict_q;

    logic             drv_any;
    logic             drv_multi;
    logic [WIDTH-1:0] drv_val;
    logic             req_valid;

    // Lowest-index driver wins; any additional driver flags contention.
    always_comb begin
        drv_any   = 1'b0;
        drv_multi = 1'b0;
        drv_val   = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (REGS_EN[i] && !REGS_RW[i]) begin
                if (drv_any) begin
                    drv_multi = 1'b1;
                end else begin
                    drv_val = regs_q[i];
                end
                drv_any = 1'b1;
            end
        end
    end

    assign BUS = (drv_any && !HALT) ? drv_val : {WIDTH{1'bz}};

    assign req_valid = COPY_REQ && (32'(COPY_SRC) < NUM_REGS) && (32'(COPY_DST) < NUM_REGS);

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
            conflict_q <= 1'b0;
        end else if (!HALT) begin
            if (drv_multi) begin
                conflict_q <= 1'b1;
            end
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                if (state_q == StWr && dst_q == IDXW'(i)) begin
                    regs_q[i] <= tmp_q;
                end else if (REGS_EN[i] && REGS_RW[i]) begin
                    regs_q[i] <= BUS;
`ifdef REGFILE_DEC_EN
                end else if (REGS_INC[i] && !REGS_DEC[i]) begin
                    regs_q[i] <= regs_q[i] + WIDTH'(1);
                end else if (REGS_DEC[i] && !REGS_INC[i]) begin
                    regs_q[i] <= regs_q[i] - WIDTH'(1);
                end
`else
                end else if (REGS_INC[i]) begin
                    regs_q[i] <= regs_q[i] + WIDTH'(1);
                end
`endif
            end
        end
    end

    // Copy engine: IDLE -> RD (capture source) -> WR (write destination) -> IDLE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            tmp_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            done_q  <= 1'b0;
        end else if (HALT) begin
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        src_q   <= COPY_SRC;
                        dst_q   <= COPY_DST;
                        state_q <= StRd;
                    end
                end
                StRd: begin
                    tmp_q   <= regs_q[src_q];
                    state_q <= StWr;
                end
                StWr: begin
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ALU_IN1   = regs_q[ALU_A_IDX];
    assign ALU_IN2   = regs_q[ALU_B_IDX];
    assign OUT       = regs_q[NUM_REGS-1];
    assign COPY_BUSY = (state_q != StIdle);
    assign COPY_DONE = done_q;
    assign CONFLICT  = conflict_q;

endmodule

// File: tb/tb_bat_regfile.sv
// Directed self-checking bench for bat_regfile (default 16-bit, 8-register build).
module tb_bat_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        halt;
    wire  [15:0] bus;
    logic [7:0]  en;
    logic [7:0]  rw;
    logic [7:0]  inc;
`ifdef REGFILE_DEC_EN
    logic [7:0]  dec;
`endif
    logic [15:0] alu_in1;
    logic [15:0] alu_in2;
    logic [15:0] out_val;
    logic        copy_req;
    logic [2:0]  copy_src;
    logic [2:0]  copy_dst;
    logic        copy_busy;
    logic        copy_done;
    logic        conflict;

    logic        tb_drv_en;
    logic [15:0] tb_drv;
    int          n_cmp = 0;
    int          n_err = 0;

    assign bus = tb_drv_en ? tb_drv : 16'hzzzz;

    always #5 clk = ~clk;

    bat_regfile dut (
        .CLK      (clk),
        .RST      (rst),
        .HALT     (halt),
        .BUS      (bus),
        .REGS_EN  (en),
        .REGS_RW  (rw),
        .REGS_INC (inc),
`ifdef REGFILE_DEC_EN
        .REGS_DEC (dec),
`endif
        .ALU_IN1  (alu_in1),
        .ALU_IN2  (alu_in2),
        .OUT      (out_val),
        .COPY_REQ (copy_req),
        .COPY_SRC (copy_src),
        .COPY_DST (copy_dst),
        .COPY_BUSY(copy_busy),
        .COPY_DONE(copy_done),
        .CONFLICT (conflict)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic quiet();
        en = '0; rw = '0; inc = '0; halt = 1'b0; copy_req = 1'b0; tb_drv_en = 1'b0;
`ifdef REGFILE_DEC_EN
        dec = '0;
`endif
    endtask

    task automatic load(input int idx, input logic [15:0] val);
        en = 8'(1 << idx); rw = 8'(1 << idx); tb_drv = val; tb_drv_en = 1'b1;
        step();
        quiet();
    endtask

    task automatic read_reg(input string tag, input int idx, input logic [15:0] exp);
        en = 8'(1 << idx); rw = '0; tb_drv_en = 1'b0;
        #1;
        check(tag, bus, exp);
        en = '0;
        #1;
    endtask

    initial begin
        rst = 1'b1; copy_src = '0; copy_dst = '0; tb_drv = '0;
        quiet();
        step();
        rst = 1'b0;

        // 1: dirty state, then reset clears everything
        load(2, 16'($urandom));
        load(7, 16'h5A5A);
        en = 8'h28; rw = '0;
        step();
        quiet();
        check("pre_rst_conflict", 16'(conflict), 16'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_out", out_val, 16'h0000);
        check("rst_conflict", 16'(conflict), 16'h0);
        check("rst_busy", 16'(copy_busy), 16'h0);
        check("rst_done", 16'(copy_done), 16'h0);
        tb_drv = 16'h0000; tb_drv_en = 1'b1; #1;
        check("rst_bus_released", bus, 16'h0000);
        tb_drv_en = 1'b0; #1;
        read_reg("rst_reg2", 2, 16'h0000);

        // 2: load then drive
        load(2, 16'h1234);
        read_reg("drive_reg2", 2, 16'h1234);
        check("out_untouched", out_val, 16'h0000);

        // 3: increment wrap, load beats increment
        load(7, 16'hFFFF);
        check("out_ffff", out_val, 16'hFFFF);
        inc = 8'h80;
        step();
        check("inc_wrap", out_val, 16'h0000);
        step();
        check("inc_one", out_val, 16'h0001);
        en = 8'h80; rw = 8'h80; inc = 8'h80; tb_drv = 16'h0050; tb_drv_en = 1'b1;
        step();
        quiet();
        check("load_over_inc", out_val, 16'h0050);

        // 4: two drivers, lowest wins, sticky conflict
        load(3, 16'h3333);
        load(5, 16'h5555);
        en = 8'h28; rw = '0; #1;
        check("multi_drive_low", bus, 16'h3333);
        check("conflict_pre_edge", 16'(conflict), 16'h0);
        step();
        quiet();
        check("conflict_set", 16'(conflict), 16'h1);
        step();
        step();
        check("conflict_sticky", 16'(conflict), 16'h1);

        // 5: copy r0 -> r1, inc on dst in WR, second request ignored
        load(0, 16'h00AA);
        load(1, 16'h1111);
        check("alu_in1", alu_in1, 16'h00AA);
        copy_req = 1'b1; copy_src = 3'd0; copy_dst = 3'd1;
        step();
        check("busy_rd", 16'(copy_busy), 16'h1);
        copy_src = 3'd2;
        step();
        copy_req = 1'b0;
        inc = 8'h02;
        check("busy_wr", 16'(copy_busy), 16'h1);
        check("done_wr", 16'(copy_done), 16'h0);
        check("dst_before", alu_in2, 16'h1111);
        step();
        inc = '0;
        check("copy_result", alu_in2, 16'h00AA);
        check("done_pulse", 16'(copy_done), 16'h1);
        check("idle_after", 16'(copy_busy), 16'h0);
        step();
        check("done_cleared", 16'(copy_done), 16'h0);
        check("no_second_copy", alu_in2, 16'h00AA);
        check("idle_stays", 16'(copy_busy), 16'h0);

        // 6: halt mid-copy r4 -> r6
        load(4, 16'h0444);
        copy_req = 1'b1; copy_src = 3'd4; copy_dst = 3'd6;
        step();
        copy_req = 1'b0;
        halt = 1'b1; inc = 8'hFF; en = 8'h10; rw = '0; tb_drv = 16'h0000; tb_drv_en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check("halt_busy", 16'(copy_busy), 16'h1);
            check("halt_out", out_val, 16'h0050);
            check("halt_alu1", alu_in1, 16'h00AA);
            check("halt_bus_z", bus, 16'h0000);
        end
        quiet();
        step();
        check("resume_wr", 16'(copy_busy), 16'h1);
        check("resume_no_done", 16'(copy_done), 16'h0);
        step();
        check("resume_done", 16'(copy_done), 16'h1);
        read_reg("copy_dst6", 6, 16'h0444);
        read_reg("copy_src4", 4, 16'h0444);

`ifdef REGFILE_DEC_EN
        load(7, 16'h0000);
        dec = 8'h80;
        step();
        check("dec_wrap", out_val, 16'hFFFF);
        inc = 8'h80;
        step();
        quiet();
        check("inc_dec_hold", out_val, 16'hFFFF);
`endif

        rst = 1'b1;
        step();
        rst = 1'b0;
        check("conflict_cleared", 16'(conflict), 16'h0);
        check("out_cleared", out_val, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
